// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RISC-V fetch stage: PC, 2-entry fetch queue, redirect/flush.
// Optional misaligned-redirect trap built when FETCH_MISALIGN_TRAP_EN is defined.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready,
  output logic        fetch_misaligned
);

  typedef enum logic {RUN, TRAP} state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] q_pc    [2];
  logic [31:0] q_instr [2];
  logic        head;
  logic        tail;
  logic [1:0]  count;
  logic        pop;
  logic        push;
  logic        redirect_trap;
  logic [31:0] redirect_target;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redirect_trap    = (redirect_pc[1:0] != 2'b00);
  assign redirect_target  = redirect_pc;
  assign fetch_misaligned = (state == TRAP);
`else
  assign redirect_trap    = 1'b0;
  assign redirect_target  = {redirect_pc[31:2], 2'b00};
  assign fetch_misaligned = 1'b0;
`endif

  assign pop  = (count != 2'd0) && id_ready;
  assign push = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);
  // With count==2 the tail wraps onto the head slot, which a same-cycle pop frees.
  assign tail = head ^ count[0];

  assign imem_addr = pc;
  assign if_valid  = (count != 2'd0);
  assign if_instr  = q_instr[head];
  assign if_pc     = q_pc[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = redirect_trap ? TRAP : RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      count <= 2'd0;
      head  <= 1'b0;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      count <= 2'd0;
      head  <= 1'b0;
    end else begin
      if (push) begin
        pc <= pc + 32'd4;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only observed while count marks them valid.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      q_pc[tail]    <= pc;
      q_instr[tail] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a queue-based model.
module tb_instr_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        fetch_misaligned;

  int total = 0;
  int bad = 0;
  logic [31:0] salt = 32'h0;

  logic [63:0] mq[$];
  logic [31:0] mpc;
  bit          mtrap;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready), .fetch_misaligned(fetch_misaligned)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (32'h0000_0013 + (a >> 2)) ^ salt;
  endfunction

  assign imem_instr = mem_word(imem_addr);

  task automatic model_step();
    int n = mq.size();
    bit pop = (n != 0) && id_ready;
    if (rst) begin
      mq.delete();
      mpc = RESET_PC;
      mtrap = 0;
    end else if (redirect_valid) begin
      mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      mpc = redirect_pc;
      mtrap = (redirect_pc[1:0] != 2'b00);
`else
      mpc = redirect_pc & ~32'h3;
      mtrap = 0;
`endif
    end else begin
      if (pop) void'(mq.pop_front());
      if (!mtrap && (n < 2 || pop)) begin
        mq.push_back({mpc, mem_word(mpc)});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    apply_reset();
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", if_valid); end
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%b want=0", fetch_misaligned); end
    total++; if (imem_addr !== RESET_PC) begin bad++; $display("FAIL reset_addr got=%h want=%h", imem_addr, RESET_PC); end
    cycle();
    total++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin bad++; $display("FAIL reset_first got=%b/%h want=1/%h", if_valid, if_pc, RESET_PC); end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 16; k++) begin
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(k * 4) || if_instr !== 32'(32'h13 + k)) begin
        bad++;
        $display("FAIL stream[%0d] got=%b/%h/%h want=1/%h/%h", k, if_valid, if_pc, if_instr, k * 4, 32'h13 + k);
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    id_ready = 1'b0;
    apply_reset();
    cycle();
    for (int i = 0; i < 5; i++) cycle();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin bad++; $display("FAIL bp_head got=%b/%h want=1/0", if_valid, if_pc); end
    total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_addr got=%h want=8", imem_addr); end
    id_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instr !== mem_word(32'(i * 4))) begin
        bad++;
        $display("FAIL bp_drain[%0d] got=%b/%h want=1/%h", i, if_valid, if_pc, i * 4);
      end
      cycle();
    end
  endtask

  task automatic test_redirect_full();
    id_ready = 1'b0;
    cycle(); cycle(); cycle();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cycle();
    redirect_valid = 1'b0;
    total++; if (if_valid !== 1'b0) begin bad++; $display("FAIL redir_flush got=%b want=0", if_valid); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr got=%h want=40", imem_addr); end
    cycle();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== mem_word(32'h40)) begin bad++; $display("FAIL redir_head got=%b/%h want=1/40", if_valid, if_pc); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    for (int i = 0; i < 3; i++) begin
      total++;
      if (if_valid !== 1'b1 || if_pc !== exp_pc[i]) begin bad++; $display("FAIL wrap[%0d] got=%b/%h want=1/%h", i, if_valid, if_pc, exp_pc[i]); end
      cycle();
    end
  endtask

  task automatic test_misaligned();
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    cycle();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fetch_misaligned !== 1'b1 || if_valid !== 1'b0) begin bad++; $display("FAIL trap[%0d] got=%b/%b want=1/0", i, fetch_misaligned, if_valid); end
      cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    cycle();
    redirect_valid = 1'b0;
    total++; if (fetch_misaligned !== 1'b0) begin bad++; $display("FAIL trap_exit got=%b want=0", fetch_misaligned); end
    cycle();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h80) begin bad++; $display("FAIL trap_resume got=%b/%h want=1/80", if_valid, if_pc); end
`else
    total++; if (fetch_misaligned !== 1'b0 || imem_addr !== 32'h40) begin bad++; $display("FAIL misal_addr got=%b/%h want=0/40", fetch_misaligned, imem_addr); end
    cycle();
    total++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin bad++; $display("FAIL misal_head got=%b/%h want=1/40", if_valid, if_pc); end
`endif
  endtask

  task automatic test_reset_mid();
    id_ready = 1'b0;
    cycle(); cycle(); cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    total++; if (if_valid !== 1'b0 || fetch_misaligned !== 1'b0 || imem_addr !== RESET_PC) begin
      bad++; $display("FAIL rst_full got=%b/%b/%h want=0/0/%h", if_valid, fetch_misaligned, imem_addr, RESET_PC);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    redirect_valid = 1'b0;
    total++; if (if_valid !== 1'b0 || fetch_misaligned !== 1'b0 || imem_addr !== RESET_PC) begin
      bad++; $display("FAIL rst_redir got=%b/%b/%h want=0/0/%h", if_valid, fetch_misaligned, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    salt = $urandom;
    for (int i = 0; i < 400; i++) begin
      id_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = $urandom;
      if ($urandom_range(0, 1) == 0) redirect_pc[1:0] = 2'b00;
      rst = ($urandom_range(0, 63) == 0);
      cycle();
      total++; if (imem_addr !== mpc) begin bad++; $display("FAIL rnd_addr[%0d] got=%h want=%h", i, imem_addr, mpc); end
      total++; if (if_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid[%0d] got=%b want=%b", i, if_valid, mq.size() != 0); end
      total++; if (fetch_misaligned !== mtrap) begin bad++; $display("FAIL rnd_misal[%0d] got=%b want=%b", i, fetch_misaligned, mtrap); end
      if (mq.size() != 0) begin
        total++;
        if ({if_pc, if_instr} !== mq[0]) begin bad++; $display("FAIL rnd_head[%0d] got=%h/%h want=%h", i, if_pc, if_instr, mq[0]); end
      end
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_wrap();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
